// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : 4x4 active-low matrix keypad scan with press/release debounce
// Revision: 1.0
// ============================================================================
module keypad_scanner #(
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   localparam logic [3:0] c_debounce_n = 4'(DEBOUNCE);

   typedef enum logic [1:0] {
      FR_NONE   = 2'd0,
      FR_SINGLE = 2'd1,
      FR_MULTI  = 2'd2
   } frame_t;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_PRESSED  = 2'd2
   } state_t;

   logic [3:0] r_row_m;
   logic [3:0] r_row_s;
   logic [1:0] r_c;
   logic [1:0] r_acc_cnt;
   logic [3:0] r_acc_key;
   logic       r_frame_vld;
   frame_t     r_frame_cls;
   logic [3:0] r_frame_key;

   state_t     r_state;
   logic [3:0] r_cand;
   logic [3:0] r_n;
   logic [3:0] r_key_code;
   logic       r_key_valid;
   logic       r_key_down;

   logic [3:0] w_col_low;
   logic [2:0] w_col_cnt;
   logic [1:0] w_col_sat;
   logic [1:0] w_col_row;
   logic [2:0] w_tot_raw;
   logic [1:0] w_tot;
   logic [3:0] w_tot_key;

   state_t     w_state_nx;
   logic [3:0] w_cand_nx;
   logic [3:0] w_n_nx;
   logic [3:0] w_code_nx;
   logic       w_valid_nx;
   logic       w_down_nx;

   assign col       = ~(4'b0001 << r_c);
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_down  = r_key_down;

   // Low-bit count saturates at 2: only none / one / many matters per frame.
   assign w_col_low = ~r_row_s;
   assign w_col_cnt = {2'b00, w_col_low[0]} + {2'b00, w_col_low[1]}
                    + {2'b00, w_col_low[2]} + {2'b00, w_col_low[3]};
   assign w_col_sat = (w_col_cnt >= 3'd2) ? 2'd2 : w_col_cnt[1:0];
   assign w_tot_raw = {1'b0, r_acc_cnt} + {1'b0, w_col_sat};
   assign w_tot     = (w_tot_raw >= 3'd2) ? 2'd2 : w_tot_raw[1:0];
   assign w_tot_key = (r_acc_cnt == 2'd0 && w_col_cnt == 3'd1) ? {w_col_row, r_c} : r_acc_key;

   always_comb begin
      w_col_row = 2'd0;
      if (w_col_low[3]) w_col_row = 2'd3;
      if (w_col_low[2]) w_col_row = 2'd2;
      if (w_col_low[1]) w_col_row = 2'd1;
      if (w_col_low[0]) w_col_row = 2'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_row_m     <= 4'hF;
         r_row_s     <= 4'hF;
         r_c         <= 2'd0;
         r_acc_cnt   <= 2'd0;
         r_acc_key   <= 4'h0;
         r_frame_vld <= 1'b0;
         r_frame_cls <= FR_NONE;
         r_frame_key <= 4'h0;
      end else begin
         r_row_m     <= row;
         r_row_s     <= r_row_m;
         r_frame_vld <= 1'b0;
         if (tick) begin
            r_c <= r_c + 2'd1;
            if (r_c == 2'd3) begin
               r_frame_vld <= 1'b1;
               r_frame_key <= w_tot_key;
               r_frame_cls <= (w_tot == 2'd0) ? FR_NONE :
                              (w_tot == 2'd1) ? FR_SINGLE : FR_MULTI;
               r_acc_cnt   <= 2'd0;
               r_acc_key   <= 4'h0;
            end else begin
               r_acc_cnt   <= w_tot;
               r_acc_key   <= w_tot_key;
            end
         end
      end
   end

   // Frame results arrive one clk after the closing tick, so outputs follow one clk later.
   always_comb begin
      w_state_nx = r_state;
      w_cand_nx  = r_cand;
      w_n_nx     = r_n;
      w_code_nx  = r_key_code;
      w_valid_nx = 1'b0;
      w_down_nx  = r_key_down;
      if (r_frame_vld) begin
         case (r_state)
            S_IDLE: begin
               if (r_frame_cls == FR_SINGLE) begin
                  w_cand_nx = r_frame_key;
                  if (c_debounce_n == 4'd1) begin
                     w_state_nx = S_PRESSED;
                     w_code_nx  = r_frame_key;
                     w_valid_nx = 1'b1;
                     w_down_nx  = 1'b1;
                     w_n_nx     = 4'd0;
                  end else begin
                     w_state_nx = S_DEBOUNCE;
                     w_n_nx     = 4'd1;
                  end
               end
            end
            S_DEBOUNCE: begin
               if (r_frame_cls == FR_SINGLE && r_frame_key == r_cand) begin
                  if (r_n + 4'd1 == c_debounce_n) begin
                     w_state_nx = S_PRESSED;
                     w_code_nx  = r_cand;
                     w_valid_nx = 1'b1;
                     w_down_nx  = 1'b1;
                     w_n_nx     = 4'd0;
                  end else begin
                     w_n_nx = r_n + 4'd1;
                  end
               end else if (r_frame_cls == FR_SINGLE) begin
                  w_cand_nx = r_frame_key;
                  w_n_nx    = 4'd1;
               end else begin
                  w_state_nx = S_IDLE;
                  w_n_nx     = 4'd0;
               end
            end
            S_PRESSED: begin
               if (r_frame_cls == FR_NONE) begin
                  if (r_n + 4'd1 == c_debounce_n) begin
                     w_state_nx = S_IDLE;
                     w_down_nx  = 1'b0;
                     w_n_nx     = 4'd0;
                  end else begin
                     w_n_nx = r_n + 4'd1;
                  end
               end else begin
                  w_n_nx = 4'd0;
               end
            end
            default: begin
               w_state_nx = S_IDLE;
               w_n_nx     = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cand      <= 4'h0;
         r_n         <= 4'd0;
         r_key_code  <= 4'h0;
         r_key_valid <= 1'b0;
         r_key_down  <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_cand      <= w_cand_nx;
         r_n         <= w_n_nx;
         r_key_code  <= w_code_nx;
         r_key_valid <= w_valid_nx;
         r_key_down  <= w_down_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner : scoreboard bench for keypad_scanner with a switch-matrix model
// Revision: 1.0
// ============================================================================
module tb_keypad_scanner;

   logic        clk;
   logic        rst;
   logic        tick;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;

   logic [15:0] keys;
   logic        row_force;

   int          n_cmp;
   int          n_fail;
   int          vcnt;
   int          tick_cnt;
   int          tick_idx;
   int          frame_cnt;
   logic [3:0]  exp_q[$];

   keypad_scanner #(.DEBOUNCE(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pressed key k shorts row k/4 to column k%4.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      if (row_force) row = 4'h0;
   end

   initial begin
      int tdiv;
      tdiv = 0;
      tick = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            tdiv = 0;
            tick = 1'b0;
         end else begin
            tick = (tdiv == 3);
            tdiv = (tdiv + 1) % 4;
         end
      end
   end

   initial begin
      tick_cnt  = 0;
      tick_idx  = 0;
      frame_cnt = 0;
      forever begin
         @(posedge clk);
         if (rst) tick_idx = 0;
         else if (tick) begin
            if (tick_idx % 4 == 3) frame_cnt++;
            tick_idx++;
            tick_cnt++;
         end
      end
   end

   // Monitor: every key_valid pulse must match the oldest queued expectation.
   initial begin
      logic       prev_valid;
      logic [3:0] exp;
      prev_valid = 1'b0;
      vcnt = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (key_valid && prev_valid) begin
               n_cmp++; n_fail++;
               $display("FAIL valid_width: key_valid high 2 clk, required 1");
            end
            if (key_valid) begin
               vcnt++;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_valid: key_code=%0d, required no pulse", key_code);
               end else begin
                  exp = exp_q.pop_front();
                  if (key_code !== exp || key_down !== 1'b1) begin
                     n_fail++;
                     $display("FAIL valid_code: key_code=%0d key_down=%b, required %0d / 1",
                              key_code, key_down, exp);
                  end
               end
            end
         end
         prev_valid = key_valid;
      end
   end

   function automatic logic [15:0] km(input int k);
      logic [15:0] one;
      one = 16'd1;
      return one << k;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tick();
      int t;
      int budget;
      t = tick_cnt;
      budget = 20;
      while (tick_cnt == t && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (tick_cnt == t) begin
         n_cmp++; n_fail++;
         $display("FAIL tick_timeout: no tick within 20 clk, required one");
      end
   endtask

   // Wait n frame closes, present the next key set at once, then let outputs settle.
   task automatic run(input int n, input logic [15:0] next_keys);
      int target;
      int budget;
      target = frame_cnt + n;
      budget = n * 16 + 40;
      while (frame_cnt < target && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (frame_cnt < target) begin
         n_cmp++; n_fail++;
         $display("FAIL frame_timeout: got %0d frames, required %0d", frame_cnt, target);
      end
      keys = next_keys;
      step(2);
   endtask

   initial begin
      logic [3:0] col_seq [4];
      int v0;
      col_seq[0] = 4'b1101; col_seq[1] = 4'b1011; col_seq[2] = 4'b0111; col_seq[3] = 4'b1110;
      n_cmp = 0; n_fail = 0;
      keys = 16'h0; row_force = 1'b1; rst = 1'b1;

      // Reset state and column walk
      step(2);
      check("rst_col", col, 4'b1110);
      check("rst_valid", key_valid, 0);
      check("rst_down", key_down, 0);
      check("rst_code", key_code, 0);
      rst = 1'b0; row_force = 1'b0;
      check("col_start", col, 4'b1110);
      for (int i = 0; i < 4; i++) begin
         wait_tick();
         check($sformatf("col_step%0d", i), col, col_seq[i]);
      end
      keys = km(9);

      // Single press of key 9, then release
      v0 = vcnt;
      run(2, km(9));
      check("k9_early_valid", vcnt, v0);
      check("k9_early_down", key_down, 0);
      exp_q.push_back(4'd9);
      run(1, 16'h0);
      check("k9_valid_cnt", vcnt, v0 + 1);
      check("k9_down", key_down, 1);
      check("k9_code", key_code, 9);
      run(2, 16'h0);
      check("k9_hold_down", key_down, 1);
      run(1, km(9));
      check("k9_release", key_down, 0);
      check("k9_no_extra", vcnt, v0 + 1);

      // Bounce: 2 present, 1 absent, 3 present
      v0 = vcnt;
      run(2, 16'h0);
      check("bounce_2", vcnt, v0);
      run(1, km(9));
      check("bounce_gap", vcnt, v0);
      run(2, km(9));
      check("bounce_pre", vcnt, v0);
      exp_q.push_back(4'd9);
      run(1, 16'h0);
      check("bounce_valid", vcnt, v0 + 1);
      run(3, km(0) | km(15));
      check("bounce_release", key_down, 0);

      // Two keys together are rejected; key 0 alone is accepted
      v0 = vcnt;
      run(5, km(0));
      check("multi_none", vcnt, v0);
      check("multi_down", key_down, 0);
      run(2, km(0));
      check("k0_early", vcnt, v0);
      exp_q.push_back(4'd0);
      run(1, 16'h0);
      check("k0_valid", vcnt, v0 + 1);
      check("k0_code", key_code, 0);
      run(3, km(5));
      check("k0_release", key_down, 0);

      // Held key changes from 5 to 6 without release
      v0 = vcnt;
      run(2, km(5));
      exp_q.push_back(4'd5);
      run(1, km(6));
      check("k5_code", key_code, 5);
      run(4, 16'h0);
      check("k6_held_code", key_code, 5);
      check("k6_held_down", key_down, 1);
      check("k6_held_valid", vcnt, v0 + 1);
      run(3, km(6));
      check("k5_release", key_down, 0);
      run(2, km(6));
      check("k6_early", vcnt, v0 + 1);
      exp_q.push_back(4'd6);
      run(1, 16'h0);
      check("k6_code", key_code, 6);
      run(3, km(3));
      check("k6_release", key_down, 0);

      // Reset in the middle of debouncing key 3
      v0 = vcnt;
      run(2, km(3));
      check("k3_pre_rst", vcnt, v0);
      wait_tick();
      rst = 1'b1;
      step(2);
      check("mid_rst_code", key_code, 0);
      check("mid_rst_col", col, 4'b1110);
      rst = 1'b0;
      run(2, km(3));
      check("k3_after_rst_2", vcnt, v0);
      exp_q.push_back(4'd3);
      run(1, 16'h0);
      check("k3_valid", vcnt, v0 + 1);
      check("k3_code", key_code, 3);
      run(3, 16'h0);
      check("k3_release", key_down, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
